// File: rtl/clause_select_pkg.sv
// Shared types and LFSR helpers for the clause-select sequencer.
package clause_select_pkg;

  localparam int unsigned LFSR_W = 32;
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    VALID  = 2'd2
  } state_t;

  // Galois right-shift step.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
    lfsr_next = (l >> 1) ^ (l[0] ? LFSR_TAP_MASK : LFSR_W'(0));
  endfunction

endpackage

// File: rtl/lfsr32_galois.sv
// 32-bit Galois LFSR with seed load (priority) and single-step advance.
module lfsr32_galois
  import clause_select_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_advance,
  input  logic        in_load,
  input  logic [31:0] in_value,
  output logic [31:0] out_state
);

  logic [31:0] r_state;

  // A zero seed would lock the LFSR, so it falls back to SEED.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SEED;
    end else if (in_load) begin
      r_state <= (in_value == 32'd0) ? SEED : in_value;
    end else if (in_advance) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign out_state = r_state;

endmodule

// File: rtl/clause_select_sequencer.sv
// Drives compare-tree settings from an LFSR, captures the root result after
// settling, and hands it off over valid/ready while counting satisfied rounds.
module clause_select_sequencer
  import clause_select_pkg::*;
#(
  parameter int unsigned MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX = 2,
  parameter int unsigned NUM_TREE_NODES                     = 3,
  parameter int unsigned SETTLE_CYCLES                      = 1,
  parameter logic [31:0] LFSR_SEED                          = 32'hACE1_2468,
  parameter int unsigned SAT_COUNT_WIDTH                    = 8
) (
  input  logic                                         clk,
  input  logic                                         reset,
  input  logic                                         in_start,
  input  logic                                         in_seed_load,
  input  logic [31:0]                                  in_seed,
  input  logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] in_root_clause_index,
  input  logic                                         in_root_clause_satisfied,
  input  logic                                         in_ready,
  output logic [NUM_TREE_NODES-1:0]                    out_setting,
  output logic                                         out_busy,
  output logic                                         out_valid,
  output logic [MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX-1:0] out_clause_index,
  output logic                                         out_clause_satisfied,
  output logic [SAT_COUNT_WIDTH-1:0]                   out_sat_rounds
);

  localparam int unsigned IDX_W = MAXIMUM_BIT_WIDTH_OF_CLAUSES_INDEX;
  localparam int unsigned CNT_W = 4;
  localparam logic [SAT_COUNT_WIDTH-1:0] SAT_MAX = '1;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_next;
  logic                   w_advance;
  logic                   w_capture;
  logic                   w_accept;
  logic [31:0]            w_lfsr;
  logic                   w_unused_lfsr;

  logic                   r_busy;
  logic                   r_valid;
  logic [IDX_W-1:0]       r_index;
  logic                   r_sat;
  logic [SAT_COUNT_WIDTH-1:0] r_sat_rounds;

  lfsr32_galois #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk        (clk),
    .reset      (reset),
    .in_advance (w_advance),
    .in_load    (in_seed_load),
    .in_value   (in_seed),
    .out_state  (w_lfsr)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_advance    = 1'b0;
    w_capture    = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_start) begin
          w_advance    = 1'b1;
          w_cnt_next   = CNT_W'(SETTLE_CYCLES - 1);
          w_state_next = SETTLE;
        end
      end
      SETTLE: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CNT_W'(1);
        end else begin
          w_capture    = 1'b1;
          w_state_next = VALID;
        end
      end
      VALID: begin
        if (in_ready) begin
          w_accept     = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Result registers; held until the next capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy       <= 1'b0;
      r_valid      <= 1'b0;
      r_index      <= '0;
      r_sat        <= 1'b0;
      r_sat_rounds <= '0;
    end else begin
      r_busy  <= (w_state_next != IDLE);
      r_valid <= (w_state_next == VALID);
      if (w_capture) begin
        r_index <= in_root_clause_index;
        r_sat   <= in_root_clause_satisfied;
      end
      if (w_accept) begin
        if (!r_sat) begin
          r_sat_rounds <= '0;
        end else if (r_sat_rounds != SAT_MAX) begin
          r_sat_rounds <= r_sat_rounds + SAT_COUNT_WIDTH'(1);
        end
      end
    end
  end

  assign w_unused_lfsr        = ^w_lfsr;
  assign out_setting          = w_lfsr[NUM_TREE_NODES-1:0];
  assign out_busy             = r_busy;
  assign out_valid            = r_valid;
  assign out_clause_index     = r_index;
  assign out_clause_satisfied = r_sat;
  assign out_sat_rounds       = r_sat_rounds;

endmodule

// File: tb/tb_clause_select_sequencer.sv
// Directed self-checking bench for clause_select_sequencer (default and 2-bit counter variants).
module tb_clause_select_sequencer;

  logic        clk;
  logic        reset;
  logic        in_start;
  logic        in_seed_load;
  logic [31:0] in_seed;
  logic [1:0]  in_root_clause_index;
  logic        in_root_clause_satisfied;
  logic        in_ready;

  logic [2:0]  out_setting,  out_setting2;
  logic        out_busy,     out_busy2;
  logic        out_valid,    out_valid2;
  logic [1:0]  out_clause_index, out_clause_index2;
  logic        out_clause_satisfied, out_clause_satisfied2;
  logic [7:0]  out_sat_rounds;
  logic [1:0]  out_sat_rounds2;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m_lfsr;

  clause_select_sequencer dut (
    .clk                      (clk),
    .reset                    (reset),
    .in_start                 (in_start),
    .in_seed_load             (in_seed_load),
    .in_seed                  (in_seed),
    .in_root_clause_index     (in_root_clause_index),
    .in_root_clause_satisfied (in_root_clause_satisfied),
    .in_ready                 (in_ready),
    .out_setting              (out_setting),
    .out_busy                 (out_busy),
    .out_valid                (out_valid),
    .out_clause_index         (out_clause_index),
    .out_clause_satisfied     (out_clause_satisfied),
    .out_sat_rounds           (out_sat_rounds)
  );

  clause_select_sequencer #(.SAT_COUNT_WIDTH(2)) dut2 (
    .clk                      (clk),
    .reset                    (reset),
    .in_start                 (in_start),
    .in_seed_load             (in_seed_load),
    .in_seed                  (in_seed),
    .in_root_clause_index     (in_root_clause_index),
    .in_root_clause_satisfied (in_root_clause_satisfied),
    .in_ready                 (in_ready),
    .out_setting              (out_setting2),
    .out_busy                 (out_busy2),
    .out_valid                (out_valid2),
    .out_clause_index         (out_clause_index2),
    .out_clause_satisfied     (out_clause_satisfied2),
    .out_sat_rounds           (out_sat_rounds2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] model_next(input logic [31:0] l);
    model_next = l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full round with immediate acceptance; checks settings and captured values.
  task automatic do_round(input logic [1:0] idx, input logic sat);
    in_root_clause_index     = idx;
    in_root_clause_satisfied = sat;
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    m_lfsr = model_next(m_lfsr);
    check("round_setting", 32'(out_setting), 32'(m_lfsr[2:0]));
    tick();
    check("round_valid", 32'(out_valid), 32'd1);
    check("round_sat", 32'(out_clause_satisfied), 32'(sat));
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    check("round_done", 32'(out_valid), 32'd0);
  endtask

  initial begin
    reset = 1'b1; in_start = 1'b0; in_seed_load = 1'b0; in_seed = 32'd0;
    in_root_clause_index = 2'd0; in_root_clause_satisfied = 1'b0; in_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    m_lfsr = 32'hACE1_2468;

    check("rst_valid",   32'(out_valid), 32'd0);
    check("rst_busy",    32'(out_busy), 32'd0);
    check("rst_index",   32'(out_clause_index), 32'd0);
    check("rst_sat",     32'(out_clause_satisfied), 32'd0);
    check("rst_rounds",  32'(out_sat_rounds), 32'd0);
    check("rst_setting", 32'(out_setting), 32'd0);
    check("rst_lfsr",    dut.w_lfsr, 32'hACE1_2468);

    // First round: index 2, unsatisfied, consumer stalls for 5 cycles.
    in_root_clause_index = 2'd2; in_root_clause_satisfied = 1'b0;
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    m_lfsr = 32'h5670_9234;
    check("r1_setting", 32'(out_setting), 32'd4);
    check("r1_lfsr",    dut.w_lfsr, 32'h5670_9234);
    check("r1_busy",    32'(out_busy), 32'd1);
    check("r1_notvalid", 32'(out_valid), 32'd0);
    tick();
    check("r1_valid", 32'(out_valid), 32'd1);
    check("r1_index", 32'(out_clause_index), 32'd2);
    check("r1_sat",   32'(out_clause_satisfied), 32'd0);
    in_root_clause_index = 2'd1; in_root_clause_satisfied = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_index", 32'(out_clause_index), 32'd2);
      check("hold_sat",   32'(out_clause_satisfied), 32'd0);
    end
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;
    check("acc_valid",  32'(out_valid), 32'd0);
    check("acc_busy",   32'(out_busy), 32'd0);
    check("acc_rounds", 32'(out_sat_rounds), 32'd0);
    check("acc_index_kept", 32'(out_clause_index), 32'd2);

    // Consecutive satisfied rounds then one unsatisfied.
    for (int i = 1; i <= 3; i++) begin
      do_round(2'(i), 1'b1);
      check("sat_count",  32'(out_sat_rounds), 32'(i));
      check("sat_count2", 32'(out_sat_rounds2), 32'(i));
    end
    do_round(2'd3, 1'b0);
    check("sat_clear",  32'(out_sat_rounds), 32'd0);
    check("sat_clear2", 32'(out_sat_rounds2), 32'd0);

    // Saturation of the 2-bit counter.
    for (int i = 1; i <= 5; i++) begin
      do_round(2'd0, 1'b1);
      check("sat5_count", 32'(out_sat_rounds), 32'(i));
      check("sat5_count2", 32'(out_sat_rounds2), (i > 3) ? 32'd3 : 32'(i));
    end

    // Zero seed falls back to the reset seed.
    in_seed_load = 1'b1; in_seed = 32'd0;
    tick();
    in_seed_load = 1'b0;
    m_lfsr = 32'hACE1_2468;
    check("seed0_lfsr", dut.w_lfsr, 32'hACE1_2468);
    check("seed0_busy", 32'(out_busy), 32'd0);

    // Seed load wins over the advance on a simultaneous start.
    in_seed_load = 1'b1; in_seed = 32'h1; in_start = 1'b1;
    tick();
    in_seed_load = 1'b0; in_start = 1'b0;
    m_lfsr = 32'h1;
    check("ldst_setting", 32'(out_setting), 32'd1);
    check("ldst_lfsr",    dut.w_lfsr, 32'h1);
    check("ldst_busy",    32'(out_busy), 32'd1);
    tick();
    check("ldst_valid", 32'(out_valid), 32'd1);
    in_ready = 1'b1;
    tick();
    in_ready = 1'b0;

    // Start held through SETTLE and VALID, including the accept cycle.
    in_start = 1'b1;
    tick();
    m_lfsr = model_next(m_lfsr);
    check("ign_settle_lfsr", dut.w_lfsr, m_lfsr);
    tick();
    check("ign_valid_lfsr", dut.w_lfsr, m_lfsr);
    check("ign_valid", 32'(out_valid), 32'd1);
    in_ready = 1'b1;
    tick();
    in_start = 1'b0; in_ready = 1'b0;
    check("ign_acc_lfsr", dut.w_lfsr, m_lfsr);
    check("ign_acc_busy", 32'(out_busy), 32'd0);
    tick();
    check("ign_idle_busy",  32'(out_busy), 32'd0);
    check("ign_idle_valid", 32'(out_valid), 32'd0);
    check("ign_idle_lfsr",  dut.w_lfsr, m_lfsr);

    // Reset in SETTLE abandons the round.
    in_start = 1'b1;
    tick();
    in_start = 1'b0;
    check("rs_busy_pre", 32'(out_busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rs_busy",   32'(out_busy), 32'd0);
    check("rs_valid",  32'(out_valid), 32'd0);
    check("rs_lfsr",   dut.w_lfsr, 32'hACE1_2468);
    check("rs_rounds", 32'(out_sat_rounds), 32'd0);
    tick(); tick();
    check("rs_no_result", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
